// File: rtl/fetch_if_id_stage_if.sv
// Instruction-memory request/response channel between the fetch stage (master)
// and instruction memory (slave). One request outstanding at a time.
interface fetch_if_id_stage_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_if_id_stage.sv
// Fetch stage plus IF/ID pipeline register: owns the PC, keeps one imem request
// in flight, parks a response that lands while ID is stalled, and squashes on flush.
module fetch_if_id_stage #(
    parameter int          XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_IFID,
    input  logic                 flush,
    input  logic [XLEN-1:0]      branch_target,
    fetch_if_id_stage_if.master  imem,
    output logic [31:0]          instr_ID,
    output logic [XLEN-1:0]      pc_ID,
    output logic                 valid_ID
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetchState_e;

    fetchState_e     state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] reqAddr_q, reqAddr_d;
    logic [31:0]     bufInstr_q, bufInstr_d;
    logic [XLEN-1:0] bufPc_q, bufPc_d;
    logic [31:0]     instrId_q, instrId_d;
    logic [XLEN-1:0] pcId_q, pcId_d;
    logic            validId_q, validId_d;

    logic            accept;
    logic [XLEN-1:0] alignedTarget;

    assign alignedTarget  = {branch_target[XLEN-1:2], 2'b00};
    // Reset gates the request so a response arriving during reset can never be accepted.
    assign imem.imem_req  = (state_q != HOLD) && !reset;
    assign imem.imem_addr = reqAddr_q;
    assign accept         = imem.imem_req && imem.imem_rvalid;

    assign instr_ID = instrId_q;
    assign pc_ID    = pcId_q;
    assign valid_ID = validId_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            reqAddr_q  <= RESET_PC;
            bufInstr_q <= NOP_INSTR;
            bufPc_q    <= '0;
            instrId_q  <= NOP_INSTR;
            pcId_q     <= '0;
            validId_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            reqAddr_q  <= reqAddr_d;
            bufInstr_q <= bufInstr_d;
            bufPc_q    <= bufPc_d;
            instrId_q  <= instrId_d;
            pcId_q     <= pcId_d;
            validId_q  <= validId_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        reqAddr_d  = reqAddr_q;
        bufInstr_d = bufInstr_q;
        bufPc_d    = bufPc_q;
        instrId_d  = instrId_q;
        pcId_d     = pcId_q;
        validId_d  = validId_q;

        unique case (state_q)
            FETCH: begin
                if (accept) begin
                    if (flush) begin
                        pc_d      = alignedTarget;
                        reqAddr_d = alignedTarget;
                        validId_d = 1'b0;
                        instrId_d = NOP_INSTR;
                    end else if (stall_IFID) begin
                        bufInstr_d = imem.imem_rdata;
                        bufPc_d    = reqAddr_q;
                        pc_d       = reqAddr_q + XLEN'(4);
                        state_d    = HOLD;
                    end else begin
                        instrId_d = imem.imem_rdata;
                        pcId_d    = reqAddr_q;
                        validId_d = 1'b1;
                        reqAddr_d = reqAddr_q + XLEN'(4);
                        pc_d      = reqAddr_q + XLEN'(4);
                    end
                end else if (flush) begin
                    // Address must stay put until memory answers; the redirect waits in pc.
                    pc_d      = alignedTarget;
                    validId_d = 1'b0;
                    instrId_d = NOP_INSTR;
                    state_d   = DRAIN;
                end else if (!stall_IFID) begin
                    validId_d = 1'b0;
                    instrId_d = NOP_INSTR;
                end
            end

            HOLD: begin
                if (flush) begin
                    pc_d      = alignedTarget;
                    reqAddr_d = alignedTarget;
                    validId_d = 1'b0;
                    instrId_d = NOP_INSTR;
                    state_d   = FETCH;
                end else if (!stall_IFID) begin
                    instrId_d = bufInstr_q;
                    pcId_d    = bufPc_q;
                    validId_d = 1'b1;
                    reqAddr_d = bufPc_q + XLEN'(4);
                    pc_d      = bufPc_q + XLEN'(4);
                    state_d   = FETCH;
                end
            end

            DRAIN: begin
                if (flush) begin
                    pc_d      = alignedTarget;
                    validId_d = 1'b0;
                    instrId_d = NOP_INSTR;
                end else if (!stall_IFID) begin
                    validId_d = 1'b0;
                    instrId_d = NOP_INSTR;
                end
                // Stale response is dropped; the most recent redirect target wins.
                if (accept) begin
                    reqAddr_d = flush ? alignedTarget : pc_q;
                    state_d   = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

endmodule
